// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - AES InvSubBytes stage, BPC bytes per clock through shared inverse S-boxes
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  always_comb begin
    s = 8'h00;
    case (a)
      8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
      8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
      8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
      8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
      8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
      8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
      8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
      8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
      8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
      8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
      8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
      8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
      8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
      8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
      8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
      8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
      8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
      8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
      8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
      8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
      8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
      8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
      8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
      8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
      8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
      8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
      8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
      8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
      8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
      8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
      8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
      8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
    endcase
  end

endmodule

module inv_sub_bytes_seq #(
  parameter int BPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bpc_check
    $error("BPC must be one of 1, 2, 4, 8, 16");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t       state, state_nxt;
  logic [127:0] work, work_nxt;
  logic [3:0]   idx;
  logic [3:0]   pos    [BPC];
  logic [7:0]   sb_in  [BPC];
  logic [7:0]   sb_out [BPC];
  logic         last_grp;
  logic         accept;

  // byte n lives at bits [127-8n -: 8], so lane j addresses offset 120-8*(idx+j)
  for (genvar j = 0; j < BPC; j++) begin : g_lane
    assign pos[j]   = idx + 4'(j);
    assign sb_in[j] = work[(7'd120 - {pos[j], 3'b000}) +: 8];
    inv_sbox u_sbox (.a(sb_in[j]), .s(sb_out[j]));
  end

  always_comb begin
    work_nxt = work;
    for (int j = 0; j < BPC; j++) begin
      work_nxt[(7'd120 - {pos[j], 3'b000}) +: 8] = sb_out[j];
    end
  end

  assign last_grp  = (idx == 4'(16 - BPC));
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (last_grp) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      idx       <= '0;
      out_state <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        work <= in_state;
        idx  <= '0;
      end else if (state == BUSY) begin
        work <= work_nxt;
        idx  <= idx + 4'(BPC);
        // result is published only once, so out_state never shows a partial state
        if (last_grp) out_state <= work_nxt;
      end
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb/tb_inv_sub_bytes_seq.sv - randomized bench for inv_sub_bytes_seq at BPC=1,4,16
module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_s  [3];
  logic         out_ready_s [3];
  logic         in_ready_s  [3];
  logic         out_valid_s [3];
  logic         busy_s      [3];
  logic [127:0] in_state_s  [3];
  logic [127:0] out_state_s [3];

  int total = 0;
  int bad   = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int B = (g == 0) ? 1 : (g == 1) ? 4 : 16;
    inv_sub_bytes_seq #(.BPC(B)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid_s[g]),
      .in_ready (in_ready_s[g]),
      .in_state (in_state_s[g]),
      .out_valid(out_valid_s[g]),
      .out_ready(out_ready_s[g]),
      .out_state(out_state_s[g]),
      .busy     (busy_s[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int bpc_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // forward S-box from first principles: GF(2^8) inverse followed by the affine map
  function automatic logic [7:0] fwd_byte(input int x);
    logic [7:0] b;
    b = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
    end
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_fwd(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_tab[x[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] sub_inv(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[x[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input int k, input logic [127:0] x);
    in_state_s[k] = x;
    in_valid_s[k] = 1'b1;
    #1 check("accept_ready", 128'(in_ready_s[k]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid_s[k] = 1'b0;
  endtask

  task automatic wait_out(input int k, input int n0, input logic [127:0] exp, input string tag);
    int n;
    n = n0;
    while (!out_valid_s[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 128'(n), 128'(16 / bpc_of(k)));
    check(tag, out_state_s[k], exp);
  endtask

  task automatic take(input int k);
    out_ready_s[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_s[k] = 1'b0;
    #1 check("drained", 128'(out_valid_s[k]), 128'd0);
  endtask

  initial begin
    logic [127:0] x;
    logic [127:0] y;
    logic         seen;

    for (int i = 0; i < 256; i++) fwd_tab[i] = fwd_byte(i);
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid_s[k]  = 1'b0;
      out_ready_s[k] = 1'b0;
      in_state_s[k]  = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", 128'(in_ready_s[k]), 128'd1);
      check("rst_out_valid", 128'(out_valid_s[k]), 128'd0);
      check("rst_busy", 128'(busy_s[k]), 128'd0);
      check("rst_out_state", out_state_s[k], 128'h0);
    end

    send(0, {16{8'h63}});
    wait_out(0, 0, 128'h0, "all63");
    take(0);

    for (int k = 0; k < 3; k++) begin
      send(k, 128'h637C777BF26B6FC53001672BFED7AB76);
      wait_out(k, 0, 128'h000102030405060708090A0B0C0D0E0F, "fips_vec");
      take(k);
      send(k, {16{8'h00}});
      wait_out(k, 0, {16{8'h52}}, "all00");
      take(k);
      send(k, {16{8'hFF}});
      wait_out(k, 0, {16{8'h7D}}, "allff");
      take(k);
      repeat (3) @(negedge clk);
      check("idle_hold", out_state_s[k], {16{8'h7D}});
    end

    for (int k = 0; k < 3; k++) begin
      for (int v = 0; v < 1000; v++) begin
        x = rand128();
        send(k, sub_fwd(x));
        wait_out(k, 0, x, "roundtrip");
        take(k);
      end
    end

    for (int k = 0; k < 3; k += 2) begin
      x = rand128();
      send(k, sub_fwd(x));
      wait_out(k, 0, x, "stall_first");
      for (int i = 0; i < 20; i++) begin
        check("stall_hold", out_state_s[k], x);
        check("stall_ready", 128'(in_ready_s[k]), 128'd0);
        check("stall_valid", 128'(out_valid_s[k]), 128'd1);
        @(negedge clk);
      end
      y = rand128();
      out_ready_s[k] = 1'b1;
      in_valid_s[k]  = 1'b1;
      in_state_s[k]  = y;
      #1 check("b2b_ready", 128'(in_ready_s[k]), 128'd1);
      @(posedge clk);
      @(negedge clk);
      out_ready_s[k] = 1'b0;
      in_valid_s[k]  = 1'b0;
      wait_out(k, 0, sub_inv(y), "b2b");
      take(k);
    end

    x = rand128();
    send(0, sub_fwd(x));
    for (int i = 0; i < 5; i++) begin
      in_valid_s[0] = 1'b1;
      in_state_s[0] = rand128();
      #1 check("busy_flag", 128'(busy_s[0]), 128'd1);
      check("busy_ready", 128'(in_ready_s[0]), 128'd0);
      @(negedge clk);
      in_valid_s[0] = 1'b0;
    end
    wait_out(0, 5, x, "busy_ignore");
    take(0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid_s[0]) seen = 1'b1;
    end
    check("no_extra", 128'(seen), 128'd0);

    x = rand128();
    send(0, sub_fwd(x));
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("mid_rst_valid", 128'(out_valid_s[0]), 128'd0);
    check("mid_rst_state", out_state_s[0], 128'h0);
    check("mid_rst_ready", 128'(in_ready_s[0]), 128'd1);
    check("mid_rst_busy", 128'(busy_s[0]), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    y = rand128();
    send(0, sub_fwd(y));
    wait_out(0, 0, y, "post_rst");
    take(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
